sdram_rd_streamer: RTL and testbench



---
 rtl/sdram_pkg.sv | 15 +
 rtl/sdram_skid_buf.sv | 50 +++++
 rtl/sdram_rd_streamer.sv | 138 +++++++++++++
 tb/tb_sdram_rd_streamer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM read-port streamer.
package sdram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_STREAM,
    ST_FIN
  } state_t;

endpackage

// File: rtl/sdram_skid_buf.sv
// Two-entry register buffer between the read FIFO output and the stream port.
module sdram_skid_buf
  import sdram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_occ;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= 2'd0;
    end else if (push && !pop) begin
      r_occ <= r_occ + 2'd1;
    end else if (pop && !push) begin
      r_occ <= r_occ - 2'd1;
    end
  end

  // Entries carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (push && r_occ == 2'd1) begin
        r_head <= din;
      end else begin
        r_head <= r_tail;
      end
    end else if (push && r_occ == 2'd0) begin
      r_head <= din;
    end
    if (push && ((r_occ == 2'd1 && !pop) || (r_occ == 2'd2 && pop))) begin
      r_tail <= din;
    end
  end

  assign dout = r_head;
  assign occ  = r_occ;

endmodule

// File: rtl/sdram_rd_streamer.sv
// Pops one frame from the SDRAM read FIFO and forwards it as a valid/ready
// stream with a last marker.
module sdram_rd_streamer
  import sdram_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int LOAD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              sdram_init_done,
  output logic              rd_load,
  output logic              sdram_read_valid,
  input  logic              rdf_empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int LCW = (LOAD_CYC < 2) ? 1 : $clog2(LOAD_CYC);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYC - 1);

  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_sent;
  logic [LCW-1:0]    r_load_cnt;
  logic              r_inflight;

  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_head;
  logic              w_stream;
  logic              w_valid;
  logic              w_pop;
  logic              w_last;
  logic              w_rd_en;
  logic              w_flush;

  assign w_stream = (r_state == ST_STREAM);
  assign w_valid  = (w_occ != 2'd0);
  assign w_pop    = w_valid && m_ready;
  assign w_last   = w_valid && (r_sent == r_len - LEN_W'(1));
  assign w_flush  = abort && (r_state != ST_IDLE);

  // A pop in the same cycle frees a slot, which keeps one word per clock flowing.
  assign w_rd_en = w_stream && !abort && !rst && !rdf_empty && (r_issued < r_len) &&
                   (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  sdram_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(w_flush),
    .push (r_inflight),
    .pop  (w_pop),
    .din  (rd_data),
    .dout (w_head),
    .occ  (w_occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_load_cnt <= '0;
      r_inflight <= 1'b0;
    end else if (w_flush) begin
      r_state    <= ST_IDLE;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len      <= frame_len;
            r_issued   <= '0;
            r_sent     <= '0;
            r_load_cnt <= '0;
            r_state    <= (frame_len == '0) ? ST_FIN : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_load_cnt == LOAD_LAST) begin
            r_state <= ST_ARM;
          end else begin
            r_load_cnt <= r_load_cnt + LCW'(1);
          end
        end
        ST_ARM: begin
          if (sdram_init_done) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_rd_en) begin
            r_issued <= r_issued + LEN_W'(1);
          end
          if (w_pop) begin
            r_sent <= r_sent + LEN_W'(1);
            if (w_last) begin
              r_state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          r_issued <= '0;
          r_sent   <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_load          = (r_state == ST_LOAD);
  assign sdram_read_valid = w_stream;
  assign rd_en            = w_rd_en;
  assign m_valid          = w_valid;
  assign m_data           = w_valid ? w_head : '0;
  assign m_last           = w_last;
  assign busy             = (r_state != ST_IDLE);
  assign done             = (r_state == ST_FIN);

endmodule

// File: tb/tb_sdram_rd_streamer.sv
// Bench for sdram_rd_streamer: queue-based FIFO model plus a word scoreboard.
`timescale 1ns/1ps
module tb_sdram_rd_streamer;

  localparam int DATA_W   = 16;
  localparam int LEN_W    = 24;
  localparam int LOAD_CYC = 4;
  localparam int FIFO_D   = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              sdram_init_done = 1'b0;
  logic              rdf_empty = 1'b1;
  logic [DATA_W-1:0] rd_data = '0;
  logic              m_ready = 1'b0;
  logic              rd_load, sdram_read_valid, rd_en, m_valid, m_last, busy, done;
  logic [DATA_W-1:0] m_data;

  int checks = 0;
  int errors = 0;

  // FIFO model and stimulus knobs
  logic [DATA_W-1:0] fifo_mem [FIFO_D];
  int fifo_wr = 0, fifo_rd = 0;
  int gap_every = 0, gap_len = 0, gap_cnt = 0, pop_cnt = 0;
  int ready_mode = 0, ready_ph = 0;

  // Reference frame and observation counters
  logic [DATA_W-1:0] exp_mem [64];
  int exp_len = 0;
  int cyc = 0, n_rden = 0, n_xfer = 0, n_load = 0, n_done = 0, n_busy = 0;
  int rden_base = 0, xfer_base = 0, load_base = 0, done_base = 0, busy_base = 0;
  int rden_cyc[$];
  int xfer_cyc[$];

  always #5 clk = ~clk;

  sdram_rd_streamer #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .LOAD_CYC(LOAD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len),
    .sdram_init_done(sdram_init_done), .rd_load(rd_load),
    .sdram_read_valid(sdram_read_valid), .rdf_empty(rdf_empty), .rd_en(rd_en),
    .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  task automatic drive_model();
    bit pop_now, load_now;
    forever begin
      @(posedge clk);
      pop_now  = rd_en;
      load_now = rd_load;
      #1;
      if (load_now) begin
        fifo_rd = fifo_wr;
        pop_cnt = 0;
        gap_cnt = 0;
      end
      if (pop_now) begin
        rd_data = fifo_mem[fifo_rd % FIFO_D];
        fifo_rd++;
        pop_cnt++;
        if (gap_every > 0 && (pop_cnt % gap_every) == 0) gap_cnt = gap_len;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      rdf_empty = (fifo_rd >= fifo_wr) || (gap_cnt > 0);
      case (ready_mode)
        1: m_ready = ((ready_ph % 4) == 0) || ((ready_ph % 4) == 3);
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      ready_ph++;
    end
  endtask

  task automatic monitor();
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    int idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en) begin
        checks++;
        if (rdf_empty || !sdram_read_valid) begin
          errors++;
          $display("FAIL rd_en_gating: rd_en=1 with rdf_empty=%0b read_valid=%0b (cycle %0d)",
                   rdf_empty, sdram_read_valid, cyc);
        end
        checks++;
        if (n_rden - rden_base >= exp_len) begin
          errors++;
          $display("FAIL rd_en_overrun: pop #%0d, required at most %0d", n_rden - rden_base + 1, exp_len);
        end
        n_rden++;
        rden_cyc.push_back(cyc);
      end
      if (!sdram_init_done) begin
        checks++;
        if (rd_en || sdram_read_valid) begin
          errors++;
          $display("FAIL init_gate: rd_en=%0b read_valid=%0b, required 0 0", rd_en, sdram_read_valid);
        end
      end
      checks++;
      if (dut.w_occ > 2'd2) begin
        errors++;
        $display("FAIL occ_bound: occ=%0d, required <= 2", dut.w_occ);
      end
      if (m_valid && m_ready) begin
        idx = n_xfer - xfer_base;
        checks++;
        if (idx >= exp_len) begin
          errors++;
          $display("FAIL xfer_extra: word #%0d data %h, frame has %0d words", idx, m_data, exp_len);
        end else if (m_data !== exp_mem[idx]) begin
          errors++;
          $display("FAIL xfer_data: word #%0d got %h required %h", idx, m_data, exp_mem[idx]);
        end
        checks++;
        if (m_last !== (idx == exp_len - 1)) begin
          errors++;
          $display("FAIL m_last: word #%0d got %0b required %0b", idx, m_last, (idx == exp_len - 1));
        end
        n_xfer++;
        xfer_cyc.push_back(cyc);
      end else if (!m_valid) begin
        checks++;
        if (m_last !== 1'b0) begin
          errors++;
          $display("FAIL last_no_valid: m_last=%0b with m_valid=0, required 0", m_last);
        end
      end
      if (prev_stall && m_valid) begin
        checks++;
        if (m_data !== prev_data || m_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got %h/%0b required %h/%0b", m_data, m_last, prev_data, prev_last);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (rd_load) n_load++;
      if (done)    n_done++;
      if (busy)    n_busy++;
    end
  endtask

  task automatic snapshot(input int len);
    exp_len   = len;
    xfer_base = n_xfer;
    rden_base = n_rden;
    load_base = n_load;
    done_base = n_done;
    busy_base = n_busy;
  endtask

  // Start a frame, wait out the FIFO flush, then load the frame's words.
  task automatic launch(input int len, input bit rand_data, output bit ok);
    int guard;
    logic [DATA_W-1:0] w;
    snapshot(len);
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    if (len == 0) return;
    guard = 0;
    while (rd_load !== 1'b1 && guard < 20) begin @(posedge clk); #2; guard++; end
    while (rd_load === 1'b1 && guard < 40) begin @(posedge clk); #2; guard++; end
    if (guard >= 20) ok = 1'b0;
    for (int k = 0; k < len; k++) begin
      w = rand_data ? DATA_W'($urandom) : DATA_W'(k);
      exp_mem[k] = w;
      fifo_mem[fifo_wr % FIFO_D] = w;
      fifo_wr++;
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (done !== 1'b0)             begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
    checks++; if (rd_load !== 1'b0)          begin errors++; $display("FAIL reset_rd_load: got %0b required 0", rd_load); end
    checks++; if (sdram_read_valid !== 1'b0) begin errors++; $display("FAIL reset_read_valid: got %0b required 0", sdram_read_valid); end
    checks++; if (rd_en !== 1'b0)            begin errors++; $display("FAIL reset_rd_en: got %0b required 0", rd_en); end
    checks++; if (m_valid !== 1'b0)          begin errors++; $display("FAIL reset_m_valid: got %0b required 0", m_valid); end
    checks++; if (m_last !== 1'b0)           begin errors++; $display("FAIL reset_m_last: got %0b required 0", m_last); end
    checks++; if (m_data !== '0)             begin errors++; $display("FAIL reset_m_data: got %h required 0", m_data); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b required 0", busy); end
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    sdram_init_done = 1'b1;
    ready_mode = 0;
    gap_every = 0;
    launch(8, 1'b0, ok1);
    wait_idle(300, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL basic_timeout: launch=%0b idle=%0b required 1 1", ok1, ok2); end
    checks++; if (n_load - load_base != LOAD_CYC) begin errors++; $display("FAIL basic_rd_load: %0d clk, required %0d", n_load - load_base, LOAD_CYC); end
    checks++; if (n_rden - rden_base != 8) begin errors++; $display("FAIL basic_rd_en: %0d pops, required 8", n_rden - rden_base); end
    checks++; if (n_xfer - xfer_base != 8) begin errors++; $display("FAIL basic_words: %0d, required 8", n_xfer - xfer_base); end
    checks++; if (n_done - done_base != 1) begin errors++; $display("FAIL basic_done: %0d pulses, required 1", n_done - done_base); end
    if (xfer_cyc.size() >= xfer_base + 8 && rden_cyc.size() > rden_base) begin
      checks++;
      if (xfer_cyc[xfer_base + 7] - xfer_cyc[xfer_base] != 7) begin
        errors++; $display("FAIL basic_throughput: 8 words span %0d clk, required 7", xfer_cyc[xfer_base + 7] - xfer_cyc[xfer_base]);
      end
      checks++;
      if (xfer_cyc[xfer_base] - rden_cyc[rden_base] != 2) begin
        errors++; $display("FAIL basic_latency: %0d clk, required 2", xfer_cyc[xfer_base] - rden_cyc[rden_base]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    ready_mode = 1;
    launch(16, 1'b1, ok1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    frame_len = LEN_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(500, ok2);
    ready_mode = 0;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL bp_timeout: launch=%0b idle=%0b required 1 1", ok1, ok2); end
    checks++; if (n_xfer - xfer_base != 16) begin errors++; $display("FAIL bp_words: %0d, required 16", n_xfer - xfer_base); end
    checks++; if (n_rden - rden_base != 16) begin errors++; $display("FAIL bp_rd_en: %0d, required 16", n_rden - rden_base); end
    checks++; if (n_done - done_base != 1) begin errors++; $display("FAIL bp_done: %0d, required 1", n_done - done_base); end
  endtask

  task automatic test_gaps();
    bit ok1, ok2;
    gap_every = 3;
    gap_len = 5;
    launch(12, 1'b0, ok1);
    wait_idle(500, ok2);
    gap_every = 0;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL gap_timeout: launch=%0b idle=%0b required 1 1", ok1, ok2); end
    checks++; if (n_rden - rden_base != 12) begin errors++; $display("FAIL gap_rd_en: %0d, required 12", n_rden - rden_base); end
    checks++; if (n_xfer - xfer_base != 12) begin errors++; $display("FAIL gap_words: %0d, required 12", n_xfer - xfer_base); end
  endtask

  task automatic test_zero_len();
    snapshot(0);
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL zero_busy: got %0b required 1", busy); end
    checks++; if (done !== 1'b1)    begin errors++; $display("FAIL zero_done: got %0b required 1", done); end
    checks++; if (rd_load !== 1'b0) begin errors++; $display("FAIL zero_rd_load: got %0b required 0", rd_load); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end: got %0b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_end: got %0b required 0", done); end
    repeat (4) @(posedge clk);
    #2;
    checks++; if (n_busy - busy_base != 1) begin errors++; $display("FAIL zero_busy_len: %0d clk, required 1", n_busy - busy_base); end
    checks++; if (n_done - done_base != 1) begin errors++; $display("FAIL zero_done_cnt: %0d, required 1", n_done - done_base); end
    checks++; if (n_rden - rden_base != 0 || n_load - load_base != 0) begin
      errors++; $display("FAIL zero_activity: rd_en %0d rd_load %0d, required 0 0", n_rden - rden_base, n_load - load_base);
    end
  endtask

  task automatic test_init_gating();
    bit ok1, ok2;
    sdram_init_done = 1'b0;
    launch(6, 1'b1, ok1);
    repeat (50) @(posedge clk);
    #2;
    checks++; if (n_rden - rden_base != 0) begin errors++; $display("FAIL init_rd_en: %0d, required 0", n_rden - rden_base); end
    checks++; if (busy !== 1'b1 || rd_load !== 1'b0) begin errors++; $display("FAIL init_hold: busy=%0b rd_load=%0b required 1 0", busy, rd_load); end
    checks++; if (sdram_read_valid !== 1'b0) begin errors++; $display("FAIL init_read_valid: got %0b required 0", sdram_read_valid); end
    sdram_init_done = 1'b1;
    wait_idle(300, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL init_timeout: launch=%0b idle=%0b required 1 1", ok1, ok2); end
    checks++; if (n_xfer - xfer_base != 6) begin errors++; $display("FAIL init_words: %0d, required 6", n_xfer - xfer_base); end
  endtask

  task automatic test_abort(input bit use_rst);
    bit ok1, ok2;
    int guard;
    ready_mode = 0;
    launch(32, 1'b1, ok1);
    guard = 0;
    while (n_xfer - xfer_base < 5 && guard < 300) begin @(posedge clk); #2; guard++; end
    checks++; if (guard >= 300) begin errors++; $display("FAIL abort_reach: %0d words seen, required 5", n_xfer - xfer_base); end
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    abort = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_m_valid: rst=%0b got %0b required 0", use_rst, m_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: rst=%0b got %0b required 0", use_rst, busy); end
    checks++; if (rd_en !== 1'b0 || sdram_read_valid !== 1'b0) begin
      errors++; $display("FAIL abort_read: rst=%0b rd_en=%0b read_valid=%0b required 0 0", use_rst, rd_en, sdram_read_valid);
    end
    if (use_rst) begin
      checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %h required 0", m_data); end
    end
    repeat (5) @(posedge clk);
    #2;
    checks++; if (n_done - done_base != 0) begin errors++; $display("FAIL abort_done: rst=%0b %0d pulses, required 0", use_rst, n_done - done_base); end
    launch(4, 1'b1, ok1);
    wait_idle(300, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL abort_next_timeout: rst=%0b", use_rst); end
    checks++; if (n_xfer - xfer_base != 4) begin errors++; $display("FAIL abort_next_words: rst=%0b %0d, required 4", use_rst, n_xfer - xfer_base); end
    checks++; if (n_done - done_base != 1) begin errors++; $display("FAIL abort_next_done: rst=%0b %0d, required 1", use_rst, n_done - done_base); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int len;
    ready_mode = 2;
    for (int f = 0; f < 5; f++) begin
      len = $urandom_range(1, 20);
      gap_every = $urandom_range(0, 4);
      gap_len = $urandom_range(1, 3);
      launch(len, 1'b1, ok1);
      wait_idle(1000, ok2);
      checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout: frame %0d len %0d", f, len); end
      checks++; if (n_xfer - xfer_base != len) begin errors++; $display("FAIL b2b_words: frame %0d got %0d required %0d", f, n_xfer - xfer_base, len); end
      checks++; if (n_rden - rden_base != len) begin errors++; $display("FAIL b2b_rd_en: frame %0d got %0d required %0d", f, n_rden - rden_base, len); end
      checks++; if (n_done - done_base != 1) begin errors++; $display("FAIL b2b_done: frame %0d got %0d required 1", f, n_done - done_base); end
    end
    gap_every = 0;
    ready_mode = 0;
  endtask

  initial begin
    fork
      drive_model();
      monitor();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_zero_len();
    test_init_gating();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
